// File: rtl/mcp9808_temp_tracker.sv
// mcp9808_temp_tracker: paces the MCP9808 interface, captures ambient readings, tracks avg/min/max/flags.
// Define MCP9808_TRACK_ALARM_EN to add the hysteresis alarm (alarm_hi/alarm_lo inputs, alarm output).
module mcp9808_temp_tracker #(
  parameter int POLL_PERIOD = 1_000_000,
  parameter int TIMEOUT     = 65_535,
  parameter int AVG_SHIFT   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_now,
  input  logic        clr_minmax,
  input  logic        sensor_ready,
  output logic        sensor_update,
  input  logic [15:0] temp_raw,
  output logic [12:0] temp_cur,
  output logic [12:0] temp_avg,
  output logic [12:0] temp_min,
  output logic [12:0] temp_max,
  output logic [2:0]  t_flags,
  output logic        sample_valid,
  output logic [15:0] sample_cnt,
  output logic        timeout_err
`ifdef MCP9808_TRACK_ALARM_EN
  ,
  input  logic [12:0] alarm_hi,
  input  logic [12:0] alarm_lo,
  output logic        alarm
`endif
);
  localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_BUSY, WAIT_DONE, LATCH, UPDATE} state_e;
  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [WW-1:0] wait_q, wait_d;
  logic pend_q, pend_d, tout_q, tout_d, wrap;
  logic [15:0] raw_q, cnt_q;
  logic signed [12:0] x, cur_q, avg_q, min_q, max_q;
  logic signed [15:0] x_ext, avg_ext, step;
  logic [2:0] flags_q;
  logic valid_q, have_q, reload_q;
  assign wrap = enable && state_q == IDLE && timer_q == TW'(POLL_PERIOD - 1);
  always_comb begin
    state_d = state_q;
    timer_d = (enable && state_q == IDLE) ? (wrap ? '0 : timer_q + TW'(1)) : timer_q;
    wait_d  = wait_q;
    tout_d  = tout_q;
    case (state_q)
      IDLE: state_d = (pend_q && sensor_ready) ? REQ : IDLE;
      REQ: begin
        wait_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        wait_d = wait_q + WW'(1);
        if (state_q == WAIT_BUSY && !sensor_ready) begin
          wait_d  = '0;
          state_d = WAIT_DONE;
        end else if (state_q == WAIT_DONE && sensor_ready) begin
          state_d = LATCH;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end
      end
      LATCH: state_d = UPDATE;
      UPDATE: begin
        tout_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pend_d = sample_now || wrap || (pend_q && state_d != REQ);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      tout_q  <= tout_d;
    end
  end
  // Average step is arithmetic-shifted in 16 bits so it floors toward -inf.
  assign x       = raw_q[12:0];
  assign x_ext   = {{3{x[12]}}, x};
  assign avg_ext = {{3{avg_q[12]}}, avg_q};
  assign step    = (x_ext - avg_ext) >>> AVG_SHIFT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q    <= '0;
      cur_q    <= '0;
      avg_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      have_q   <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      if (state_q == LATCH) raw_q <= temp_raw;
      valid_q  <= state_q == UPDATE;
      reload_q <= clr_minmax || (reload_q && state_q != UPDATE);
      if (state_q == UPDATE) begin
        cur_q   <= x;
        flags_q <= raw_q[15:13];
        avg_q   <= have_q ? 13'(avg_ext + step) : x;
        min_q   <= (!have_q || reload_q || x < min_q) ? x : min_q;
        max_q   <= (!have_q || reload_q || x > max_q) ? x : max_q;
        cnt_q   <= &cnt_q ? cnt_q : cnt_q + 16'd1;
        have_q  <= 1'b1;
      end
    end
  end
`ifdef MCP9808_TRACK_ALARM_EN
  logic alarm_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarm_q <= 1'b0;
    else if (state_q == UPDATE) alarm_q <= (x > $signed(alarm_hi)) ? 1'b1 : (x < $signed(alarm_lo)) ? 1'b0 : alarm_q;
  end
  assign alarm = alarm_q;
`endif
  assign sensor_update = state_q == REQ;
  assign temp_cur      = cur_q;
  assign temp_avg      = avg_q;
  assign temp_min      = min_q;
  assign temp_max      = max_q;
  assign t_flags       = flags_q;
  assign sample_valid  = valid_q;
  assign sample_cnt    = cnt_q;
  assign timeout_err   = tout_q;
endmodule

// File: tb/tb_mcp9808_temp_tracker.sv
// tb_mcp9808_temp_tracker: table-driven vectors plus scoreboard of expected samples for mcp9808_temp_tracker.
module tb_mcp9808_temp_tracker;
  localparam int PP = 100, TO = 50, SH = 3;
  logic clk = 0, rst = 1, enable = 0, sample_now = 0, clr_minmax = 0, sensor_ready, sensor_update;
  logic [15:0] temp_raw, sample_cnt;
  logic [12:0] temp_cur, temp_avg, temp_min, temp_max;
  logic [2:0] t_flags;
  logic sample_valid, timeout_err;
`ifdef MCP9808_TRACK_ALARM_EN
  logic [12:0] alarm_hi = 13'h0FFF, alarm_lo = 13'h1000;
  logic alarm;
`endif
  mcp9808_temp_tracker #(.POLL_PERIOD(PP), .TIMEOUT(TO), .AVG_SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_now(sample_now), .clr_minmax(clr_minmax),
    .sensor_ready(sensor_ready), .sensor_update(sensor_update), .temp_raw(temp_raw),
    .temp_cur(temp_cur), .temp_avg(temp_avg), .temp_min(temp_min), .temp_max(temp_max),
    .t_flags(t_flags), .sample_valid(sample_valid), .sample_cnt(sample_cnt), .timeout_err(timeout_err)
`ifdef MCP9808_TRACK_ALARM_EN
    , .alarm_hi(alarm_hi), .alarm_lo(alarm_lo), .alarm(alarm)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {int cur; int avg; int mn; int mx; int flags; int cnt;} exp_t;
  typedef struct {logic [15:0] raw; bit clr; int cur; int flags;} vec_t;
  exp_t sbq[$];
  int n_chk = 0, n_fail = 0;
  logic [15:0] next_raw = 16'h0;
  bit no_drop = 0;
  bit m_have = 0, m_reload = 0;
  int m_avg, m_min, m_max, m_cnt = 0;

  // Interface model: drops ready 2 cycles after a request, for 20 cycles.
  initial begin
    sensor_ready = 1;
    temp_raw = 16'h0;
    forever begin
      @(negedge clk);
      if (sensor_update && !no_drop) begin
        repeat (2) @(negedge clk);
        sensor_ready = 0;
        repeat (20) @(negedge clk);
        temp_raw = next_raw;
        sensor_ready = 1;
      end
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  function automatic int fdiv(input int d);
    int s = 1 << SH;
    return d >= 0 ? d / s : -((-d + s - 1) / s);
  endfunction

  task automatic push_exp(input logic [15:0] raw);
    exp_t e;
    int xi = raw[12] ? int'(raw[12:0]) - 8192 : int'(raw[12:0]);
    m_avg = m_have ? m_avg + fdiv(xi - m_avg) : xi;
    if (!m_have || m_reload) begin m_min = xi; m_max = xi; end
    else begin m_min = xi < m_min ? xi : m_min; m_max = xi > m_max ? xi : m_max; end
    m_have = 1; m_reload = 0;
    m_cnt = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
    e.cur = xi & 'h1FFF; e.avg = m_avg & 'h1FFF; e.mn = m_min & 'h1FFF; e.mx = m_max & 'h1FFF;
    e.flags = int'(raw[15:13]); e.cnt = m_cnt;
    sbq.push_back(e);
  endtask

  task automatic wait_valid();
    exp_t e;
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = sample_valid; end
    chk("sample_valid_arrives", int'(got), 1);
    if (!got) return;
    chk("valid_expected", int'(sbq.size() > 0), 1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    chk("temp_cur", int'(temp_cur), e.cur);
    chk("temp_avg", int'(temp_avg), e.avg);
    chk("temp_min", int'(temp_min), e.mn);
    chk("temp_max", int'(temp_max), e.mx);
    chk("t_flags", int'(t_flags), e.flags);
    chk("sample_cnt", int'(sample_cnt), e.cnt);
    chk("timeout_err_clear", int'(timeout_err), 0);
  endtask

  task automatic pulse_now();
    sample_now = 1; @(negedge clk); sample_now = 0;
  endtask

  task automatic sample(input logic [15:0] raw, input bit clr);
    if (clr) begin clr_minmax = 1; m_reload = 1; @(negedge clk); clr_minmax = 0; end
    next_raw = raw;
    push_exp(raw);
    pulse_now();
    wait_valid();
  endtask

  task automatic wait_ready(input logic lvl);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = sensor_ready == lvl; end
    chk("sensor_ready_level", int'(ok), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_update"}, int'(sensor_update), 0);
    chk({tag, "_cur"}, int'(temp_cur), 0);
    chk({tag, "_avg"}, int'(temp_avg), 0);
    chk({tag, "_min"}, int'(temp_min), 0);
    chk({tag, "_max"}, int'(temp_max), 0);
    chk({tag, "_flags"}, int'(t_flags), 0);
    chk({tag, "_valid"}, int'(sample_valid), 0);
    chk({tag, "_cnt"}, int'(sample_cnt), 0);
    chk({tag, "_tout"}, int'(timeout_err), 0);
`ifdef MCP9808_TRACK_ALARM_EN
    chk({tag, "_alarm"}, int'(alarm), 0);
`endif
  endtask

  initial begin
    vec_t vt[8];
    int k, cnt_upd;
    bit seen;
    vt[0] = '{16'h0190, 0, 'h0190, 0};
    vt[1] = '{16'h1FF0, 0, 'h1FF0, 0};
    vt[2] = '{16'hE190, 0, 'h0190, 7};
    vt[3] = '{16'h0050, 1, 'h0050, 0};
    vt[4] = '{16'h5FFF, 0, 'h1FFF, 2};
    vt[5] = '{16'h8FFF, 0, 'h0FFF, 4};
    vt[6] = '{16'h1000, 0, 'h1000, 0};
    vt[7] = '{16'h2000, 1, 'h0000, 1};
    repeat (3) @(negedge clk);
    check_zero("reset");
    // Automatic polling: first request lands 101 cycles after enable.
    next_raw = 16'h0190;
    push_exp(16'h0190);
    rst = 0; enable = 1;
    k = 0;
    for (int i = 1; i <= 150 && k == 0; i++) begin @(negedge clk); if (sensor_update) k = i; end
    chk("poll_first_request", k, 101);
    enable = 0;
    wait_valid();
    // Table of manual samples.
    foreach (vt[i]) begin
      sample(vt[i].raw, vt[i].clr);
      chk("table_cur", int'(temp_cur), vt[i].cur);
      chk("table_flags", int'(t_flags), vt[i].flags);
      if (i == 1) begin
        chk("avg_after_neg", int'(temp_avg), 'h015C);
        chk("min_after_neg", int'(temp_min), 'h1FF0);
        chk("max_after_neg", int'(temp_max), 'h0190);
      end
      if (i == 3) begin
        chk("min_after_clr", int'(temp_min), 'h0050);
        chk("max_after_clr", int'(temp_max), 'h0050);
      end
    end
    // Timeout: interface never drops ready.
    no_drop = 1;
    pulse_now();
    k = 0;
    for (int i = 0; i < 20 && k == 0; i++) begin if (sensor_update) k = 1; else @(negedge clk); end
    chk("timeout_req_seen", k, 1);
    k = 0; seen = 0;
    for (int i = 1; i <= 100 && k == 0; i++) begin
      @(negedge clk);
      if (timeout_err) k = i;
      if (sample_valid) seen = 1;
    end
    chk("timeout_latency", k, 51);
    chk("timeout_no_valid", int'(seen), 0);
    chk("timeout_sticky", int'(timeout_err), 1);
    no_drop = 0;
    sample(16'h0100, 0);
    // Repeated sample_now during a transaction collapses into one extra sample.
    next_raw = 16'h00A0;
    push_exp(16'h00A0);
    pulse_now();
    wait_ready(0);
    pulse_now();
    repeat (3) @(negedge clk);
    pulse_now();
    push_exp(16'h00A0);
    wait_valid();
    wait_valid();
    cnt_upd = 0;
    for (int i = 0; i < 150; i++) begin @(negedge clk); cnt_upd += int'(sensor_update) + int'(sample_valid); end
    chk("no_third_sample", cnt_upd, 0);
    // Reset in WAIT_DONE.
    next_raw = 16'h0123;
    pulse_now();
    wait_ready(0);
    @(negedge clk);
    rst = 1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 0;
    m_have = 0; m_reload = 0; m_cnt = 0;
    wait_ready(1);
    repeat (5) @(negedge clk);
    chk("post_rst_idle_valid", int'(sample_valid), 0);
    sample(16'h0070, 0);
`ifdef MCP9808_TRACK_ALARM_EN
    alarm_hi = 13'h0190; alarm_lo = 13'h0100;
    sample(16'h01A0, 0);
    chk("alarm_set", int'(alarm), 1);
    sample(16'h0150, 0);
    chk("alarm_hold", int'(alarm), 1);
    sample(16'h00F0, 0);
    chk("alarm_clear", int'(alarm), 0);
`endif
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
